full_subtractor: RTL and testbench



---
 rtl/full_sub_pkg.sv | 5 +
 rtl/full_sub_cell.sv | 14 +
 rtl/full_subtractor.sv | 63 ++++++
 tb/tb_full_subtractor.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/full_sub_pkg.sv
// Shared constants for the full subtractor leaf cell and ripple chain.
package full_sub_pkg;
  localparam int FULL_SUB_MAX_WIDTH = 64;
  localparam bit FULL_SUB_RST_VAL   = 1'b0;
endpackage

// File: rtl/full_sub_cell.sv
// Single-bit full subtractor cell: one link of the ripple-borrow chain.
module full_sub_cell
  import full_sub_pkg::*;
(
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);
  assign o_d    = i_a ^ i_b ^ i_bin;
  // Borrow when a<b outright, or when bits are equal and a borrow ripples in.
  assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);
endmodule

// File: rtl/full_subtractor.sv
// Unsigned ripple-borrow subtractor {Bout,D} = a - b - Bin.
// Define FULL_SUB_REG_OUT_EN to add one output register stage (async reset to 0).
module full_subtractor
  import full_sub_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Bin,
  output logic [WIDTH-1:0] D,
  output logic             Bout
);
  generate
    if (WIDTH < 1 || WIDTH > FULL_SUB_MAX_WIDTH) begin : g_bad_width
      $error("full_subtractor: WIDTH out of range 1..64");
    end
  endgenerate

  logic [WIDTH:0]   w_br;
  logic [WIDTH-1:0] w_d;

  assign w_br[0] = Bin;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      full_sub_cell u_cell (
        .i_a    (a[i]),
        .i_b    (b[i]),
        .i_bin  (w_br[i]),
        .o_d    (w_d[i]),
        .o_bout (w_br[i+1])
      );
    end
  endgenerate

`ifdef FULL_SUB_REG_OUT_EN
  logic [WIDTH-1:0] r_d;
  logic             r_bout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d    <= {WIDTH{FULL_SUB_RST_VAL}};
      r_bout <= FULL_SUB_RST_VAL;
    end else begin
      r_d    <= w_d;
      r_bout <= w_br[WIDTH];
    end
  end

  assign D    = r_d;
  assign Bout = r_bout;
`else
  // Clock and reset stay on the port list for drop-in compatibility only.
  logic w_unused_clk_rst;
  assign w_unused_clk_rst = clk ^ rst;

  assign D    = w_d;
  assign Bout = w_br[WIDTH];
`endif
endmodule

// File: tb/tb_full_subtractor.sv
// Self-checking bench for full_subtractor at WIDTH=1 and WIDTH=8 (either build).
module tb_full_subtractor;
  logic       clk = 1'b0;
  logic       rst;
  logic       a1, b1, bin1;
  logic       d1, bout1;
  logic [7:0] a8, b8, d8;
  logic       bin8, bout8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  full_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .Bin(bin1), .D(d1), .Bout(bout1)
  );

  full_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .Bin(bin8), .D(d8), .Bout(bout8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic ia1, input logic ib1, input logic ibin1,
                       input logic [7:0] ia8, input logic [7:0] ib8, input logic ibin8);
    @(negedge clk);
    a1 = ia1; b1 = ib1; bin1 = ibin1;
    a8 = ia8; b8 = ib8; bin8 = ibin8;
  endtask

  // Wait until the result of the last drive is visible on the outputs.
  task automatic settle();
`ifdef FULL_SUB_REG_OUT_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  // Reference: plain integer subtraction folded into WIDTH+1 bits.
  function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic c);
    int diff;
    diff = int'(x) - int'(y) - int'(c);
    return 9'((diff + 512) % 512);
  endfunction

  task automatic chk8(input string tag, input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [8:0] e;
    e = ref8(x, y, c);
    chk({tag, "_d8"}, 64'(d8), 64'(e[7:0]));
    chk({tag, "_bo8"}, 64'(bout8), 64'(int'(x) < int'(y) + int'(c)));
  endtask

  initial begin
    logic [7:0] tt_d, tt_b;
    logic [2:0] row;
    logic [7:0] ra, rb;
    logic       rc;
    tt_d = 8'h96;  // D column, row 0 at bit 0
    tt_b = 8'h8E;  // Bout column, row 0 at bit 0

    rst = 1'b1;
    a1 = 0; b1 = 0; bin1 = 0; a8 = 0; b8 = 0; bin8 = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_d1", 64'(d1), 64'd0);
    chk("rst_bo1", 64'(bout1), 64'd0);
    chk("rst_d8", 64'(d8), 64'd0);
    rst = 1'b0;

    for (int r = 0; r < 8; r++) begin
      row = 3'(r);
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      drive(row[2], row[1], row[0], ra, rb, rc);
      settle();
      chk($sformatf("tt%0d_d", r), 64'(d1), 64'(tt_d[row]));
      chk($sformatf("tt%0d_bo", r), 64'(bout1), 64'(tt_b[row]));
      chk8("tt_rand", ra, rb, rc);
    end

    drive(0, 0, 0, 8'h00, 8'hFF, 1'b1); settle();
    chk("wrap_d8", 64'(d8), 64'h00);
    chk("wrap_bo8", 64'(bout8), 64'd1);
    drive(0, 0, 0, 8'h50, 8'h20, 1'b0); settle();
    chk("x50_d8", 64'(d8), 64'h30);
    chk("x50_bo8", 64'(bout8), 64'd0);
    drive(1, 1, 0, 8'hA7, 8'hA7, 1'b0); settle();
    chk("eq_d8", 64'(d8), 64'h00);
    chk("eq_bo8", 64'(bout8), 64'd0);
    chk("eq_d1", 64'(d1), 64'd0);

    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      drive(0, 0, 0, ra, rb, rc);
      settle();
      chk8("rnd", ra, rb, rc);
    end

`ifdef FULL_SUB_REG_OUT_EN
    drive(0, 0, 0, 8'h00, 8'h00, 1'b0); settle();
    drive(0, 1, 0, 8'h00, 8'h01, 1'b0);
    #1;
    chk("lat_pre_d1", 64'(d1), 64'd0);
    chk("lat_pre_bo1", 64'(bout1), 64'd0);
    @(posedge clk); #1;
    chk("lat_post_d1", 64'(d1), 64'd1);
    chk("lat_post_bo1", 64'(bout1), 64'd1);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_d1", 64'(d1), 64'd0);
    chk("arst_bo1", 64'(bout1), 64'd0);
    chk("arst_d8", 64'(d8), 64'd0);
    a1 = 1; b1 = 0; bin1 = 0; a8 = 8'h09; b8 = 8'h04; bin8 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("rst_hold_d1", 64'(d1), 64'd0);
      chk("rst_hold_bo8", 64'(bout8), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_d1", 64'(d1), 64'd1);
    chk("rel_bo1", 64'(bout1), 64'd0);
    chk8("rel", 8'h09, 8'h04, 1'b0);
`else
    drive(1, 1, 1, 8'h01, 8'h01, 1'b1);
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) @(posedge clk); else @(negedge clk);
      rst = ~rst;
      #2;
      chk("clk_ind_d1", 64'(d1), 64'd1);
      chk("clk_ind_bo1", 64'(bout1), 64'd1);
      chk("clk_ind_d8", 64'(d8), 64'hFF);
    end
    rst = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
